temp_bar_display_seq: RTL
=========================

// Module: temp_bar_display_seq
// PURPOSE
//  Registered, parametrised successor of the combinational temperature display stage.
//  Takes the averaged-temperature quotient/remainder from the divider and rounds it to the nearest integer.
//  Encodes the result as a BAR_W-segment thermometer bar.
//  Drives a debounced, hysteretic alert FSM with low/high direction flags.
//  Sits between the averaging divider and the LED/bar driver; all outputs are registered.
// PARAMETERS
//  DATA_W    16  width of temp_Q_i / temp_R_i / rounded_o
//  CNT_W     8   width of active_sensors_nr
//  BAR_W     8   bar segments; bar spans T_LOW .. T_HIGH = T_LOW+BAR_W-1
//  T_LOW     19  lowest in-range temperature (default T_HIGH = 26)
//  HYST      1   clear margin; alert clears only inside [T_LOW+HYST, T_HIGH-HYST]
//  ALERT_CNT 3   consecutive out-of-range samples needed to raise alert (>=1)
//  CLEAR_CNT 3   consecutive clear-band samples needed to drop alert (>=1)
// PORTS
//  clk_i             in   1       clock, all state on rising edge
//  rst_n_i           in   1       asynchronous reset, active low
//  valid_i           in   1       divider result valid this cycle
//  temp_Q_i          in   DATA_W  average quotient
//  temp_R_i          in   DATA_W  average remainder
//  active_sensors_nr in   CNT_W   divisor (number of active sensors)
//  valid_o           out  1       one-cycle pulse: outputs updated for a sample
//  rounded_o         out  DATA_W  rounded temperature
//  coded_out_o       out  BAR_W   thermometer bar code
//  alert_o           out  1       debounced alert
//  alert_low_o       out  1       alert_o and last out-of-range sample was < T_LOW
//  alert_high_o      out  1       alert_o and last out-of-range sample was > T_HIGH
//  sensor_err_o      out  1       pulse: sample dropped, active_sensors_nr == 0
// BEHAVIOUR
//  Reset: all outputs 0; FSM = OK; counters 0; direction flags 0.
//  Pipeline: S1 registers rounding; S2 registers code + FSM. valid_i -> valid_o latency = 2 cycles.
//   Full throughput: one sample per cycle; no backpressure.
//  Rounding: compare {R,1'b0} >= zero-extended N at DATA_W+1 bits.
//   If true, rounded = Q+1, saturating at 2^DATA_W-1; else rounded = Q.
//  Divisor zero: valid_i with N==0 -> sensor_err_o pulses at +2 cycles.
//   Such a sample produces no valid_o; outputs, FSM and counters are untouched.
//  Bar: rounded < T_LOW  -> BAR_W'b0..01.
//   rounded > T_HIGH -> all ones.
//   Otherwise k = rounded-T_LOW+1 LSB ones (19 -> 0000_0001, 22 -> 0000_1111, 26 -> 1111_1111).
//  Sample classes: OOR = outside [T_LOW,T_HIGH].
//   CLR = inside [T_LOW+HYST, T_HIGH-HYST].
//   MARGIN = in range but not CLR.
//  FSM (advances only on valid samples; cnt counts consecutive qualifying samples):
//   OK:    OOR -> cnt=1; if ALERT_CNT==1 go ALERT, else go PEND.
//   PEND:  OOR -> cnt++; on reaching ALERT_CNT go ALERT. Non-OOR -> OK, cnt=0.
//   ALERT: CLR -> cnt=1; if CLEAR_CNT==1 go OK, else go RECOV. MARGIN/OOR -> stay, cnt=0.
//   RECOV: CLR -> cnt++; on reaching CLEAR_CNT go OK. OOR -> ALERT, cnt=0. MARGIN -> ALERT, cnt=0.
//  alert_o = 1 in ALERT and RECOV, updated together with valid_o.
//  Direction latch: every OOR sample latches low/high, so a flip (low->high) while in alert updates the flags immediately.
//   Flags are 0 whenever alert_o == 0.
//  Between samples all outputs hold; valid_o and sensor_err_o are single-cycle pulses.
//  rst_n_i low mid-operation: immediate clear, in-flight pipeline samples discarded.
// TESTING
//  T1 Q=21,R=3,N=6 -> +2cyc: valid_o=1, rounded_o=22, coded_out_o=0000_1111, alert_o=0.
//  T2 Q=21,R=2,N=5 -> rounded_o=21 (4<5), code 0000_0111; Q=65535,R=1,N=1 -> rounded_o=65535 (saturated), all ones.
//  T3 samples 30,30 then 22 -> alert_o stays 0 (PEND reset). Then 30,30,30 -> alert_o=1, alert_high_o=1 on 3rd valid_o.
//  T4 in ALERT: 26 (MARGIN), 22, 22, 25, 22, 22, 22 -> alert_o stays 1 until 3rd consecutive CLR sample, then 0 with flags 0.
//  T5 in ALERT high: sample 10 -> alert_low_o=1, alert_high_o=0, alert_o=1. Back-to-back valid_i every cycle -> valid_o every cycle.
//  T6 valid_i with N=0 -> sensor_err_o pulse, no valid_o, outputs unchanged. rst_n_i low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/temp_bar_display_seq.sv
// rtl/temp_bar_display_seq.sv - registered temperature rounding, thermometer bar and debounced alert FSM
// Ports:
//   clk_i, rst_n_i           clock (rising edge), asynchronous active-low reset
//   valid_i                  divider result valid this cycle
//   temp_Q_i, temp_R_i       average quotient / remainder (DATA_W)
//   active_sensors_nr        divisor (CNT_W); zero means the sample is dropped
//   valid_o                  one-cycle pulse, outputs updated (2 cycles after valid_i)
//   rounded_o, coded_out_o   rounded temperature and BAR_W-segment thermometer code
//   alert_o, alert_low_o, alert_high_o  debounced alert and its direction
//   sensor_err_o             one-cycle pulse for a sample dropped on a zero divisor
module temp_bar_display_seq #(
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 8,
    parameter int BAR_W     = 8,
    parameter int T_LOW     = 19,
    parameter int HYST      = 1,
    parameter int ALERT_CNT = 3,
    parameter int CLEAR_CNT = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] temp_Q_i,
    input  logic [DATA_W-1:0] temp_R_i,
    input  logic [CNT_W-1:0]  active_sensors_nr,
    output logic              valid_o,
    output logic [DATA_W-1:0] rounded_o,
    output logic [BAR_W-1:0]  coded_out_o,
    output logic              alert_o,
    output logic              alert_low_o,
    output logic              alert_high_o,
    output logic              sensor_err_o
);

    localparam int T_HIGH = T_LOW + BAR_W - 1;
    localparam int MAX_CNT = (ALERT_CNT > CLEAR_CNT) ? ALERT_CNT : CLEAR_CNT;
    localparam int CW = $clog2(MAX_CNT + 1);

    localparam logic [DATA_W-1:0] LO_V     = DATA_W'(T_LOW);
    localparam logic [DATA_W-1:0] HI_V     = DATA_W'(T_HIGH);
    localparam logic [DATA_W-1:0] CLR_LO_V = DATA_W'(T_LOW + HYST);
    localparam logic [DATA_W-1:0] CLR_HI_V = DATA_W'(T_HIGH - HYST);
    localparam logic [CW-1:0]     ALERT_C  = CW'(ALERT_CNT);
    localparam logic [CW-1:0]     CLEAR_C  = CW'(CLEAR_CNT);

    typedef enum logic [1:0] {ST_OK, ST_PEND, ST_ALERT, ST_RECOV} state_t;

    // Stage 1: rounding
    logic              div_ok;
    logic              round_up;
    logic [DATA_W:0]   r_twice;
    logic [DATA_W:0]   n_ext;
    logic [DATA_W-1:0] rounded_c;

    logic              s1_valid;
    logic              s1_err;
    logic [DATA_W-1:0] s1_rounded;

    assign div_ok    = (active_sensors_nr != '0);
    assign r_twice   = {temp_R_i, 1'b0};
    assign n_ext     = (DATA_W+1)'(active_sensors_nr);
    assign round_up  = (r_twice >= n_ext);
    // Round-up of an all-ones quotient would wrap; hold it at full scale instead.
    assign rounded_c = (round_up && !(&temp_Q_i)) ? temp_Q_i + DATA_W'(1) : temp_Q_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid   <= 1'b0;
            s1_err     <= 1'b0;
            s1_rounded <= '0;
        end else begin
            s1_valid <= valid_i && div_ok;
            s1_err   <= valid_i && !div_ok;
            if (valid_i && div_ok)
                s1_rounded <= rounded_c;
        end
    end

    // Stage 2: bar code, classification and alert FSM
    logic               is_low, is_high, is_oor, is_clr;
    logic [BAR_W-1:0]   code_c;
    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n, cnt_inc;
    logic               dir_low, dir_high, dir_low_n, dir_high_n;
    logic               alert_n;

    assign is_low  = (s1_rounded < LO_V);
    assign is_high = (s1_rounded > HI_V);
    assign is_oor  = is_low || is_high;
    assign is_clr  = (s1_rounded >= CLR_LO_V) && (s1_rounded <= CLR_HI_V);
    assign cnt_inc = cnt + CW'(1);

    // Segment i lights once the temperature reaches T_LOW+i; below range only segment 0 lights.
    always_comb begin
        code_c = '0;
        for (int i = 0; i < BAR_W; i++)
            code_c[i] = (s1_rounded >= DATA_W'(T_LOW + i));
        if (is_low)
            code_c = BAR_W'(1);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_OK: begin
                cnt_n = '0;
                if (is_oor) begin
                    if (ALERT_CNT == 1) begin
                        state_n = ST_ALERT;
                    end else begin
                        state_n = ST_PEND;
                        cnt_n   = CW'(1);
                    end
                end
            end
            ST_PEND: begin
                if (!is_oor) begin
                    state_n = ST_OK;
                    cnt_n   = '0;
                end else if (cnt_inc == ALERT_C) begin
                    state_n = ST_ALERT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_ALERT: begin
                cnt_n = '0;
                if (is_clr) begin
                    if (CLEAR_CNT == 1) begin
                        state_n = ST_OK;
                    end else begin
                        state_n = ST_RECOV;
                        cnt_n   = CW'(1);
                    end
                end
            end
            default: begin
                if (!is_clr) begin
                    state_n = ST_ALERT;
                    cnt_n   = '0;
                end else if (cnt_inc == CLEAR_C) begin
                    state_n = ST_OK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
        endcase
    end

    assign alert_n    = (state_n == ST_ALERT) || (state_n == ST_RECOV);
    // Every out-of-range sample re-latches direction, so a low/high flip shows at once.
    assign dir_low_n  = is_oor ? is_low  : dir_low;
    assign dir_high_n = is_oor ? is_high : dir_high;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o      <= 1'b0;
            sensor_err_o <= 1'b0;
            rounded_o    <= '0;
            coded_out_o  <= '0;
            alert_o      <= 1'b0;
            alert_low_o  <= 1'b0;
            alert_high_o <= 1'b0;
            state        <= ST_OK;
            cnt          <= '0;
            dir_low      <= 1'b0;
            dir_high     <= 1'b0;
        end else begin
            valid_o      <= s1_valid;
            sensor_err_o <= s1_err;
            if (s1_valid) begin
                rounded_o    <= s1_rounded;
                coded_out_o  <= code_c;
                state        <= state_n;
                cnt          <= cnt_n;
                dir_low      <= dir_low_n;
                dir_high     <= dir_high_n;
                alert_o      <= alert_n;
                alert_low_o  <= alert_n && dir_low_n;
                alert_high_o <= alert_n && dir_high_n;
            end
        end
    end

endmodule
